// File: rtl/load_store_unit.sv
// Load/store unit: sequences CPU byte/half/word loads and stores onto a single-port word memory,
// using read-modify-write for sub-word stores and rejecting misaligned or out-of-range requests.
module load_store_unit #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_store,
   input  logic [2:0]        op,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              rsp_valid,
   output logic [31:0]       rdata,
   output logic              fault,
   output logic              memread,
   output logic              memwrite,
   output logic [ADDR_W-1:0] adress,
   output logic [31:0]       DataIn,
   input  logic [31:0]       outdatamemory
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                store_q;
   logic [31:0]         old_q;
   logic [31:0]         rdata_q;
   logic                fault_q;

   logic                accept;
   logic                op_bad, misaligned, out_of_range, req_fault;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         load_val;
   logic [31:0]         merged;

   assign req_ready    = (state_q == StIdle) && !rst;
   assign accept       = req_valid && req_ready;
   assign op_bad       = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
   assign misaligned   = ((op[1:0] == 2'b01) && addr[0]) ||
                         ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign out_of_range = |addr[31:ADDR_W+2];
   assign req_fault    = op_bad || misaligned || out_of_range;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_fault)                           state_d = StResp;
               else if (is_store && op[1:0] == 2'b10)   state_d = StWrite;
               else                                     state_d = StRead;
            end
         end
         StRead:  state_d = store_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Lane extraction for loads, straight from the memory read port
   always_comb begin
      byte_sel = 8'h00;
      case (addr_q[1:0])
         2'd0:    byte_sel = outdatamemory[7:0];
         2'd1:    byte_sel = outdatamemory[15:8];
         2'd2:    byte_sel = outdatamemory[23:16];
         default: byte_sel = outdatamemory[31:24];
      endcase
      half_sel = addr_q[1] ? outdatamemory[31:16] : outdatamemory[15:0];
      case (op_q)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'h0, byte_sel};
         3'b101:  load_val = {16'h0, half_sel};
         default: load_val = outdatamemory;
      endcase
   end

   always_comb begin
      merged = old_q;
      if (op_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   assign memread   = (state_q == StRead);
   assign memwrite  = (state_q == StWrite);
   assign rsp_valid = (state_q == StResp);
   assign rdata     = rdata_q;
   assign fault     = fault_q;
   assign adress    = (memread || memwrite) ? addr_q[ADDR_W+1:2] : '0;
   assign DataIn    = !memwrite ? 32'h0 : (op_q[1:0] == 2'b10) ? wdata_q : merged;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         store_q <= 1'b0;
         old_q   <= 32'h0;
         rdata_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            store_q <= is_store;
            if (req_fault) begin
               rdata_q <= 32'h0;
               fault_q <= 1'b1;
            end
         end
         if (state_q == StRead) begin
            old_q <= outdatamemory;
            if (!store_q) begin
               rdata_q <= load_val;
               fault_q <= 1'b0;
            end
         end
         // Result registers only change on entry to RESP so they hold between responses
         if (state_q == StWrite) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 5, word-index width of the downstream data memory (depth 2**ADDR_W 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU memory request present.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE, low while rst high).
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 op  input  3  size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (loads only; stores use op[1:0]).
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data (byte/half taken from LSBs).
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rdata  output  32  load result, extended per op; 0 for stores and faults.
REQ-012 fault  output  1  request rejected (misaligned or out of range), valid with rsp_valid.
REQ-013 memread  output  1  read strobe to data memory.
REQ-014 memwrite  output  1  write strobe to data memory.
REQ-015 adress  output  ADDR_W  word index to data memory.
REQ-016 DataIn  output  32  write data to data memory.
REQ-017 outdatamemory  input  32  read data from data memory, combinationally valid in the cycle memread is high.

Function
REQ-018 FSM states IDLE, READ, WRITE, RESP; request accepted on req_valid && req_ready in IDLE; op/addr/wdata/is_store captured at acceptance.
REQ-019 Word index = addr[ADDR_W+1:2]; byte offset = addr[1:0].
REQ-020 Fault when half with addr[0]=1, word with addr[1:0]!=0, addr[31:ADDR_W+2] nonzero, or op in {011,110,111}; faulting request: IDLE->RESP, no memread/memwrite ever asserted.
REQ-021 Load: IDLE->READ->RESP; READ drives memread=1, adress; outdatamemory captured at end of READ; rsp_valid 2 cycles after acceptance.
REQ-022 Load extraction: byte lane addr[1:0]*8, half lane addr[1]*16; op 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-023 Word store: IDLE->WRITE->RESP; WRITE drives memwrite=1, adress, DataIn=wdata; rsp_valid 2 cycles after acceptance.
REQ-024 Byte/half store: IDLE->READ->WRITE->RESP (read-modify-write); READ captures old word; WRITE writes old word with selected lane replaced by wdata[7:0]/wdata[15:0], other bytes unchanged; rsp_valid 3 cycles after acceptance.
REQ-025 memread and memwrite never both high; each strobe high exactly one cycle per access; adress and DataIn stable throughout strobe and 0 outside it.
REQ-026 RESP: rsp_valid=1 for one cycle, then IDLE; rdata/fault hold until next RESP.
REQ-027 req_valid ignored outside IDLE; no back-to-back acceptance in RESP (next acceptance earliest cycle after RESP).
REQ-028 Loads never write memory; stores return rdata=0.

Reset
REQ-029 rst high at a clock edge: state IDLE; rsp_valid, rdata, fault, memread, memwrite, adress, DataIn all 0.
REQ-030 rst asserted mid-operation aborts it: no strobe in any cycle after the reset edge, no rsp_valid for the aborted request.
REQ-031 req_ready=1 the first cycle after rst deasserts.

Verification
REQ-032 Preload word 1 = 0x8899AABB; LB addr 0x5 -> one memread cycle, adress=1, rsp_valid at +2, rdata=0xFFFFFFAA; LBU same -> 0x000000AA.
REQ-033 SB wdata=0x11 addr 0x6 over word 1 = 0x8899AABB -> memread then memwrite with DataIn=0x8811AABB, rsp_valid at +3; LW addr 0x4 -> 0x8811AABB.
REQ-034 SW addr 0x8 wdata=0xDEADBEEF -> memwrite one cycle, adress=2, no memread; LH addr 0xA -> 0xFFFFDEAD; LHU addr 0x8 -> 0x0000BEEF.
REQ-035 LW addr 0x6, SH addr 0x3, LW addr 0x80 -> each rsp_valid at +1 with fault=1, rdata=0, no memread/memwrite.
REQ-036 SH accepted, rst asserted in READ cycle -> no memwrite ever, no rsp_valid, memory word unchanged, req_ready=1 cycle after rst release.
REQ-037 req_valid held high across 3 LW requests -> accepted only in IDLE, strobes never overlap, responses in order.
